// File: rtl/dmem_arbiter.sv
// Round-robin arbiter for the shared data-memory port (core = req 0, loader = req 1); grant is same-cycle, response exactly one cycle later.
// Backpressure: the losing requester sees ready low and must hold its request; req1_lock bursts are capped at LOCK_MAX while req 0 waits.
module dmem_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic              req1_lock,
    output logic              req0_ready,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DATA_W-1:0] rsp0_rdata,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp1_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CNT_W = $clog2(LOCK_MAX) + 1;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    logic             last_grant;
    logic [CNT_W-1:0] run_cnt;
    logic             rsp_pend;
    logic             rsp_id;
    logic             rsp_is_rd;

    logic             locked;
    logic             grant_vld;
    logic             winner;
    req_t             win;

    // Locked mode only applies once req 1 already holds the port and its run budget remains.
    always_comb begin
        locked    = last_grant && req1_lock && (run_cnt < CNT_W'(LOCK_MAX));
        grant_vld = 1'b0;
        winner    = 1'b0;
        if (!rst) begin
            if (req0_valid && req1_valid) begin
                grant_vld = 1'b1;
                winner    = locked ? 1'b1 : ~last_grant;
            end else if (req0_valid) begin
                grant_vld = 1'b1;
                winner    = 1'b0;
            end else if (req1_valid) begin
                grant_vld = 1'b1;
                winner    = 1'b1;
            end
        end
    end

    always_comb begin
        win = '0;
        if (grant_vld) begin
            win = winner ? '{we: req1_we, addr: req1_addr, wdata: req1_wdata}
                         : '{we: req0_we, addr: req0_addr, wdata: req0_wdata};
        end
    end

    assign req0_ready = grant_vld && !winner;
    assign req1_ready = grant_vld && winner;
    assign mem_en     = grant_vld;
    assign mem_we     = win.we;
    assign mem_addr   = win.addr;
    assign mem_wdata  = win.wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= 1'b1;
            run_cnt    <= '0;
            rsp_pend   <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_is_rd  <= 1'b0;
        end else begin
            rsp_pend <= grant_vld;
            if (grant_vld) begin
                last_grant <= winner;
                rsp_id     <= winner;
                rsp_is_rd  <= ~win.we;
            end
            // The locked check caps run_cnt at LOCK_MAX, so the increment cannot overrun.
            if (!req1_lock) begin
                run_cnt <= '0;
            end else if (grant_vld) begin
                if (winner && locked && req0_valid)
                    run_cnt <= run_cnt + CNT_W'(1);
                else
                    run_cnt <= '0;
            end
        end
    end

    // Gating with rst drops a response that would otherwise land in a reset cycle.
    assign rsp0_valid = !rst && rsp_pend && !rsp_id;
    assign rsp1_valid = !rst && rsp_pend && rsp_id;
    assign rsp0_rdata = (rsp0_valid && rsp_is_rd) ? mem_rdata : '0;
    assign rsp1_rdata = (rsp1_valid && rsp_is_rd) ? mem_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed-vector bench for dmem_arbiter: grants checked in-cycle, responses via a scoreboard queue and an independent monitor.
module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req0_we = 1'b0;
    logic [31:0] req0_addr = '0, req0_wdata = '0;
    logic        req1_valid = 1'b0, req1_we = 1'b0;
    logic [31:0] req1_addr = '0, req1_wdata = '0;
    logic        req1_lock = 1'b0;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .LOCK_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req1_lock(req1_lock),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous-read memory: returns data for any access so write responses must be zeroed by the DUT.
    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEADBEEF : (32'hC0DE0000 | {16'h0, a[15:0]});
    endfunction

    always @(posedge clk) mem_rdata <= mem_en ? mem_model(mem_addr) : 32'hBAD0BAD0;

    typedef struct {
        bit          rst;
        bit          v0, we0;
        logic [31:0] a0, d0;
        bit          v1, we1;
        logic [31:0] a1, d1;
        bit          lock;
        int          g;      // 0 none, 1 req0, 2 req1
        logic [31:0] rd;     // expected response data
    } vec_t;

    typedef struct {
        int          due;
        bit          id;
        logic [31:0] rd;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];

    task automatic v(input bit r, input bit v0, input bit we0, input logic [31:0] a0, input logic [31:0] d0,
                     input bit v1, input bit we1, input logic [31:0] a1, input logic [31:0] d1,
                     input bit lock, input int g, input logic [31:0] rd);
        vec_t x;
        x.rst = r; x.v0 = v0; x.we0 = we0; x.a0 = a0; x.d0 = d0;
        x.v1 = v1; x.we1 = we1; x.a1 = a1; x.d1 = d1;
        x.lock = lock; x.g = g; x.rd = rd;
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s cyc=%0d: got %h want %h", name, cyc, act, want);
        end
    endtask

    // Response monitor: every presented response must match the head of the scoreboard on time.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rsp0_valid || rsp1_valid) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", {62'h0, rsp1_valid, rsp0_valid}, 64'h0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_valids", {62'h0, rsp1_valid, rsp0_valid}, e.id ? 64'h2 : 64'h1);
                    chk("rsp_rdata", e.id ? {32'h0, rsp1_rdata} : {32'h0, rsp0_rdata}, {32'h0, e.rd});
                    chk("rsp_other_rdata", e.id ? {32'h0, rsp0_rdata} : {32'h0, rsp1_rdata}, 64'h0);
                    chk("rsp_cycle", 64'(cyc), 64'(e.due));
                end
            end else if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
                e = exp_q.pop_front();
                chk("missing_rsp", 64'h0, e.id ? 64'h2 : 64'h1);
            end
        end
    end

    initial begin
        vec_t x;
        exp_t e;
        logic        ew;
        logic [31:0] ea, ed;

        // Reset with requests asserted: nothing may be granted.
        v(1, 1,0,32'h10,0, 1,0,32'h20,0, 0, 0, 0);
        v(1, 1,0,32'h10,0, 1,0,32'h20,0, 0, 0, 0);
        v(0, 0,0,0,0,       0,0,0,0,       0, 0, 0);
        // Single read
        v(0, 1,0,32'h10,0, 0,0,0,0,       0, 1, 32'hDEADBEEF);
        v(0, 0,0,0,0,       0,0,0,0,       0, 0, 0);
        // Contention round-robin right after reset
        v(1, 0,0,0,0,       0,0,0,0,       0, 0, 0);
        v(0, 1,0,32'h40,0, 1,0,32'h44,0, 0, 1, 32'hC0DE0040);
        v(0, 1,0,32'h40,0, 1,0,32'h44,0, 0, 2, 32'hC0DE0044);
        v(0, 1,0,32'h40,0, 1,0,32'h44,0, 0, 1, 32'hC0DE0040);
        v(0, 1,0,32'h40,0, 1,0,32'h44,0, 0, 2, 32'hC0DE0044);
        // Writes from each side
        v(0, 0,0,0,0,       1,1,32'h20,32'h12345678, 0, 2, 0);
        v(0, 1,1,32'h24,32'hCAFEF00D, 0,0,0,0, 0, 1, 0);
        // Lock bound: one round-robin grant to req1, four locked, then req0
        for (int i = 0; i < 5; i++)
            v(0, 1,0,32'h30,0, 1,0,32'h34,0, 1, 2, 32'hC0DE0034);
        v(0, 1,0,32'h30,0, 1,0,32'h34,0, 1, 1, 32'hC0DE0030);
        v(0, 1,0,32'h30,0, 1,0,32'h34,0, 1, 2, 32'hC0DE0034);
        v(0, 1,0,32'h30,0, 1,0,32'h34,0, 1, 2, 32'hC0DE0034);
        v(0, 1,0,32'h30,0, 1,0,32'h34,0, 0, 1, 32'hC0DE0030);
        // Reset mid-read: response dropped, req0 wins first contention after
        v(0, 1,0,32'h48,0, 0,0,0,0,       0, 1, 32'hC0DE0048);
        v(1, 1,0,32'h4C,0, 1,0,32'h50,0, 0, 0, 0);
        v(0, 1,0,32'h4C,0, 1,0,32'h50,0, 0, 1, 32'hC0DE004C);
        v(0, 1,0,32'h4C,0, 1,0,32'h50,0, 0, 2, 32'hC0DE0050);
        v(0, 1,0,32'h4C,0, 1,0,32'h50,0, 0, 1, 32'hC0DE004C);
        // Idle keeps last_grant: next contention goes to req1
        for (int i = 0; i < 10; i++)
            v(0, 0,0,0,0, 0,0,0,0, 0, 0, 0);
        v(0, 1,0,32'h4C,0, 1,0,32'h50,0, 0, 2, 32'hC0DE0050);
        v(0, 0,0,0,0, 0,0,0,0, 0, 0, 0);
        v(0, 0,0,0,0, 0,0,0,0, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            x = vecs[i];
            @(posedge clk);
            #1;
            rst = x.rst;
            req0_valid = x.v0; req0_we = x.we0; req0_addr = x.a0; req0_wdata = x.d0;
            req1_valid = x.v1; req1_we = x.we1; req1_addr = x.a1; req1_wdata = x.d1;
            req1_lock = x.lock;
            #1;
            ew = (x.g == 1) ? x.we0 : (x.g == 2) ? x.we1 : 1'b0;
            ea = (x.g == 1) ? x.a0  : (x.g == 2) ? x.a1  : 32'h0;
            ed = (x.g == 1) ? x.d0  : (x.g == 2) ? x.d1  : 32'h0;
            chk("ready", {62'h0, req1_ready, req0_ready}, 64'(x.g));
            chk("mem_en_we", {62'h0, mem_en, mem_we}, {62'h0, (x.g != 0), ew});
            chk("mem_addr_wdata", {mem_addr, mem_wdata}, {ea, ed});
            if (x.g != 0 && (i + 1 >= vecs.size() || !vecs[i+1].rst)) begin
                e.due = cyc + 1;
                e.id  = (x.g == 2);
                e.rd  = x.rd;
                exp_q.push_back(e);
            end
        end
        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
